// File: rtl/input_event_reporter.sv
// ---------------------------------------------------------------------------
// input_event_reporter
//
// Synchronises and debounces NUM_INPUTS asynchronous inputs. Every debounced
// change is packed into one event word and queued in a small FIFO. A Wishbone
// classic master writes each queued word to EVENT_ADDR, one word per
// transaction.
//
// Event word layout (DATA_WIDTH bits):
//   [NUM_INPUTS-1:0]             new debounced levels
//   [2*NUM_INPUTS-1:NUM_INPUTS]  mask of the channels that changed
//   [DATA_WIDTH-1]               overflow flag at the moment the word is popped
//   all other bits               0
//
// Optional feature: define INPUT_EVENT_REPORTER_WB_TIMEOUT_EN to abandon a
// write after TIMEOUT_CYCLES cycles without ack_i. Without the macro the bus
// waits for ack_i indefinitely and timeout_o is tied low.
//
// Ports:
//   clk_i       system clock
//   rst_ni      asynchronous active-low reset
//   inputs_i    raw asynchronous buttons/switches
//   stable_o    debounced input levels
//   cyc_o/stb_o Wishbone cycle/strobe
//   we_o        write enable (1 during transactions)
//   adr_o       EVENT_ADDR during transactions, else 0
//   dat_o       event word during transactions, else 0
//   sel_o       all ones during transactions, else 0
//   ack_i       Wishbone acknowledge
//   overflow_o  sticky: an event was dropped since the last delivered word
//   timeout_o   one-cycle pulse on ack timeout
// ---------------------------------------------------------------------------
module input_event_reporter #(
   parameter int                    NUM_INPUTS      = 8,
   parameter int                    DEBOUNCE_PERIOD = 5,
   parameter int                    FIFO_DEPTH      = 4,
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    ADDR_WIDTH      = 32,
   parameter logic [ADDR_WIDTH-1:0] EVENT_ADDR      = '0,
   parameter int                    TIMEOUT_CYCLES  = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_INPUTS-1:0]   inputs_i,
   output logic [NUM_INPUTS-1:0]   stable_o,
   output logic                    cyc_o,
   output logic                    stb_o,
   output logic                    we_o,
   output logic [ADDR_WIDTH-1:0]   adr_o,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic [DATA_WIDTH/8-1:0] sel_o,
   input  logic                    ack_i,
   output logic                    overflow_o,
   output logic                    timeout_o
);

   localparam int CW = $clog2(DEBOUNCE_PERIOD + 1);
   localparam int EW = 2 * NUM_INPUTS;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_PERIOD - 1);

   typedef enum logic {IDLE, BUSY} state_e;

   // ---------------- synchroniser + debounce ----------------
   logic [NUM_INPUTS-1:0] meta_q, sync_q, stable_q, stable_d, changed;
   logic [CW-1:0]         cnt_q [NUM_INPUTS];
   logic [CW-1:0]         cnt_d [NUM_INPUTS];

   // NOTE: every variable gets a default at the top of always_comb, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         cnt_d[i] = '0;
         if (sync_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) stable_d[i] = sync_q[i];
            else                      cnt_d[i]    = cnt_q[i] + CW'(1);
         end
      end
   end

   assign changed = stable_d ^ stable_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of every other flop.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q   <= '0;
         sync_q   <= '0;
         stable_q <= '0;
         for (int i = 0; i < NUM_INPUTS; i++) cnt_q[i] <= '0;
      end else begin
         meta_q   <= inputs_i;
         sync_q   <= meta_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
      end
   end

   assign stable_o = stable_q;

   // ---------------- event FIFO ----------------
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          empty, full, push_req, do_push, drop, pop;
   logic          ack_take, tmo_fire, overflow_q;
   state_e        state_q;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push_req = |changed;
   assign ack_take = (state_q == BUSY) && ack_i;
   assign pop      = ack_take || tmo_fire;
   // A pop in the same cycle frees the head slot, so a full FIFO can still
   // accept the new word.
   assign do_push  = push_req && (!full || pop);
   assign drop     = push_req && full && !pop;

   // NOTE: the storage array has no reset; only the pointers define which
   // entries are valid.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= {changed, stable_d};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         // Set wins over clear so a drop coinciding with the clearing ack
         // is still reported.
         if (drop || tmo_fire)          overflow_q <= 1'b1;
         else if (ack_take && overflow_q) overflow_q <= 1'b0;
      end
   end

   assign overflow_o = overflow_q;

   // ---------------- Wishbone controller ----------------
   logic          cyc_q;
   logic [EW-1:0] dat_q;

`ifdef INPUT_EVENT_REPORTER_WB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tmo_cnt_q;
   logic          timeout_q;

   assign tmo_fire  = (state_q == BUSY) && !ack_i && (tmo_cnt_q == TMO_LAST);
   assign timeout_o = timeout_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= tmo_fire;
         if (state_q == BUSY && !pop) tmo_cnt_q <= tmo_cnt_q + TW'(1);
         else                         tmo_cnt_q <= '0;
      end
   end
`else
   assign tmo_fire  = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               // The head stays in the FIFO until acknowledged; popping only
               // on ack keeps the word's slot counted while it is on the bus.
               if (!empty) begin
                  dat_q   <= mem_q[rd_ptr_q[AW-1:0]];
                  cyc_q   <= 1'b1;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (pop) begin
                  dat_q   <= '0;
                  cyc_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cyc_o = cyc_q;
   assign stb_o = cyc_q;
   assign we_o  = cyc_q;
   assign adr_o = cyc_q ? EVENT_ADDR : '0;
   assign sel_o = {(DATA_WIDTH/8){cyc_q}};

   // The overflow bit reflects the sticky flag at the instant the word is
   // acknowledged, so drops that happen while this word waits for its ack
   // are still reported by it.
   always_comb begin
      dat_o                 = '0;
      dat_o[EW-1:0]         = dat_q;
      dat_o[DATA_WIDTH-1]   = cyc_q && overflow_q;
   end

endmodule

// File: tb/tb_input_event_reporter.sv
module tb_input_event_reporter;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [7:0]  inputs_i;
   logic [7:0]  stable_o;
   logic        cyc_o, stb_o, we_o;
   logic [31:0] adr_o, dat_o;
   logic [3:0]  sel_o;
   logic        ack_i;
   logic        overflow_o, timeout_o;

   logic        ack_en;
   int          n_pass  = 0;
   int          n_total = 0;
   int          n_fail  = 0;
   logic [31:0] words [$];
   logic [31:0] addrs [$];

   input_event_reporter #(
      .NUM_INPUTS(8), .DEBOUNCE_PERIOD(5), .FIFO_DEPTH(4), .DATA_WIDTH(32),
      .ADDR_WIDTH(32), .EVENT_ADDR(32'h0), .TIMEOUT_CYCLES(64)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .inputs_i(inputs_i), .stable_o(stable_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .sel_o(sel_o), .ack_i(ack_i), .overflow_o(overflow_o), .timeout_o(timeout_o)
   );

   always #5 clk_i = ~clk_i;

   // Slave: one-cycle-late single ack pulse while enabled.
   initial begin
      ack_i = 1'b0;
      forever begin
         @(negedge clk_i);
         ack_i = ack_en && cyc_o && !ack_i;
      end
   end

   // Record every completed write.
   always @(posedge clk_i) begin
      if (rst_ni && cyc_o && stb_o && ack_i) begin
         words.push_back(dat_o);
         addrs.push_back(adr_o);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int i);
      if (i < words.size()) return words[i];
      return 'x;
   endfunction

   task automatic wait_words(input int n, input int budget, input string tag);
      int k = 0;
      while (words.size() < n && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check(tag, 64'(words.size() >= n), 64'd1);
   endtask

   task automatic wait_cyc(input int budget, input string tag);
      int k = 0;
      while (!cyc_o && k < budget) begin
         @(negedge clk_i);
         k++;
      end
      check(tag, 64'(cyc_o), 64'd1);
   endtask

   initial begin
      int hi, pulses;
      rst_ni   = 1'b0;
      inputs_i = 8'h00;
      ack_en   = 1'b1;
      repeat (3) @(negedge clk_i);
      check("rst_stable", 64'(stable_o), 64'h0);
      check("rst_cyc", 64'(cyc_o), 64'h0);
      check("rst_dat", 64'(dat_o), 64'h0);
      check("rst_ovf", 64'(overflow_o), 64'h0);
      rst_ni = 1'b1;
      repeat (9) @(negedge clk_i);

      // 1: single rising input
      inputs_i[0] = 1'b1;
      repeat (6) @(negedge clk_i);
      check("t1_stable_early", 64'(stable_o), 64'h00);
      @(negedge clk_i);
      check("t1_stable_on_time", 64'(stable_o), 64'h01);
      check("t1_cyc_not_yet", 64'(cyc_o), 64'h0);
      @(negedge clk_i);
      check("t1_cyc", 64'(cyc_o), 64'h1);
      check("t1_we", 64'(we_o), 64'h1);
      check("t1_sel", 64'(sel_o), 64'hF);
      check("t1_dat", 64'(dat_o), 64'h0000_0101);
      wait_words(1, 10, "t1_arrive");
      repeat (10) @(negedge clk_i);
      check("t1_count", 64'(words.size()), 64'd1);
      check("t1_word", 64'(word_at(0)), 64'h0000_0101);
      check("t1_adr", 64'(addrs[0]), 64'h0);
      check("t1_idle", 64'(cyc_o), 64'h0);

      // 2: bouncing channel 3, then settle high
      for (int i = 0; i < 6; i++) begin
         inputs_i[3] = ~inputs_i[3];
         repeat (2) @(negedge clk_i);
      end
      check("t2_no_event_stable", 64'(stable_o), 64'h01);
      check("t2_no_event_count", 64'(words.size()), 64'd1);
      inputs_i[3] = 1'b1;
      wait_words(2, 30, "t2_arrive");
      check("t2_word", 64'(word_at(1)), 64'h0000_0809);
      inputs_i[3] = 1'b0;
      wait_words(3, 30, "t2_fall_arrive");
      check("t2_fall_word", 64'(word_at(2)), 64'h0000_0801);

      // 3: two channels change together
      inputs_i = 8'h91;
      wait_words(4, 30, "t3_arrive");
      repeat (15) @(negedge clk_i);
      check("t3_count", 64'(words.size()), 64'd4);
      check("t3_word", 64'(word_at(3)), 64'h0000_9091);
      check("t3_stable", 64'(stable_o), 64'h91);

      // 4: overflow while the bus is stalled
      ack_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         inputs_i[1] = ~inputs_i[1];
         repeat (10) @(negedge clk_i);
      end
      check("t4_ovf_set", 64'(overflow_o), 64'h1);
      check("t4_stalled", 64'(cyc_o), 64'h1);
      check("t4_no_write", 64'(words.size()), 64'd4);
      check("t4_head_live", 64'(dat_o), 64'h8000_0293);
      ack_en = 1'b1;
      wait_words(8, 60, "t4_arrive");
      repeat (10) @(negedge clk_i);
      check("t4_count", 64'(words.size()), 64'd8);
      check("t4_w0", 64'(word_at(4)), 64'h8000_0293);
      check("t4_w1", 64'(word_at(5)), 64'h0000_0291);
      check("t4_w2", 64'(word_at(6)), 64'h0000_0293);
      check("t4_w3", 64'(word_at(7)), 64'h0000_0291);
      check("t4_ovf_clr", 64'(overflow_o), 64'h0);

      // 5: reset during a transaction
      ack_en = 1'b0;
      inputs_i[2] = 1'b1;
      wait_cyc(20, "t5_busy");
      check("t5_dat", 64'(dat_o), 64'h0000_0495);
      rst_ni = 1'b0;
      #1;
      check("t5_cyc_async", 64'(cyc_o), 64'h0);
      check("t5_stb_async", 64'(stb_o), 64'h0);
      check("t5_dat_async", 64'(dat_o), 64'h0);
      check("t5_stable_async", 64'(stable_o), 64'h00);
      inputs_i = 8'hFF;
      ack_en   = 1'b1;
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("t5_fifo_empty", 64'(cyc_o), 64'h0);
      wait_words(9, 30, "t5_arrive");
      repeat (10) @(negedge clk_i);
      check("t5_count", 64'(words.size()), 64'd9);
      check("t5_word", 64'(word_at(8)), 64'h0000_FFFF);
      check("t5_stable", 64'(stable_o), 64'hFF);

      // 6: no ack from the slave
      ack_en = 1'b0;
      inputs_i[0] = 1'b0;
      wait_cyc(20, "t6_busy");
      check("t6_dat", 64'(dat_o), 64'h0000_01FE);
      inputs_i[1] = 1'b0;
      hi = 0;
      pulses = 0;
`ifdef INPUT_EVENT_REPORTER_WB_TIMEOUT_EN
      while (cyc_o && hi < 200) begin
         hi++;
         @(negedge clk_i);
         pulses += int'(timeout_o);
      end
      repeat (3) begin
         @(negedge clk_i);
         pulses += int'(timeout_o);
      end
      check("t6_busy_cycles", 64'(hi), 64'd64);
      check("t6_pulses", 64'(pulses), 64'd1);
      check("t6_ovf", 64'(overflow_o), 64'h1);
      ack_en = 1'b1;
      wait_words(10, 30, "t6_arrive");
      check("t6_next_word", 64'(word_at(9)), 64'h8000_02FC);
`else
      repeat (100) begin
         @(negedge clk_i);
         pulses += int'(timeout_o);
      end
      check("t6_still_busy", 64'(cyc_o), 64'h1);
      check("t6_no_pulse", 64'(pulses), 64'd0);
      ack_en = 1'b1;
      wait_words(11, 40, "t6_arrive");
      check("t6_first", 64'(word_at(9)), 64'h0000_01FE);
      check("t6_second", 64'(word_at(10)), 64'h0000_02FC);
      check("t6_ovf", 64'(overflow_o), 64'h0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
